// File: rtl/vscale_pc_gen.sv
// Next-PC generation for the vscale fetch stage: owns PC_IF/PC_DX and replays stalled redirects.
// Optional VSCALE_PC_MISALIGN_EN: suppress BRANCH/JAL/REG targets with bit1 set and flag them.
module vscale_pc_gen #(
  parameter int              XLEN         = 32,
  parameter int              SEL_W        = 3,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] PC_src_sel,
  input  logic [31:0]      inst_DX,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  handler_PC,
  input  logic             stall_IF,
  input  logic             stall_DX,
  output logic [XLEN-1:0]  PC_PIF,
  output logic [XLEN-1:0]  PC_IF,
  output logic [XLEN-1:0]  PC_DX,
  output logic             redirect_pending
`ifdef VSCALE_PC_MISALIGN_EN
  ,
  output logic             target_misaligned
`endif
);

  localparam logic [SEL_W-1:0] SEL_BRANCH  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_REG     = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_JAL     = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_REPLAY  = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_HANDLER = SEL_W'(5);
  localparam logic [XLEN-1:0]  FOUR        = {{(XLEN-3){1'b0}}, 3'd4};

  logic [12:0]     imm_b_raw_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] branch_target_s;
  logic [XLEN-1:0] reg_target_s;
  logic [XLEN-1:0] plus4_s;
  logic            is_handler_s;
  logic            redirect_valid_s;
  logic [XLEN-1:0] redirect_target_s;
  logic            pending_valid_r;
  logic [XLEN-1:0] pending_target_r;
  logic            unused_s;
`ifdef VSCALE_PC_MISALIGN_EN
  logic            misaligned_s;
  logic            target_misaligned_r;
`endif

  assign imm_b_raw_s     = {inst_DX[31], inst_DX[7], inst_DX[30:25], inst_DX[11:8], 1'b0};
  assign imm_b_s         = {{(XLEN-13){imm_b_raw_s[12]}}, imm_b_raw_s};
  assign branch_target_s = PC_DX + imm_b_s;
  assign reg_target_s    = {rs1_data[XLEN-1:1], 1'b0};
  assign plus4_s         = PC_IF + FOUR;
  assign is_handler_s    = (PC_src_sel == SEL_HANDLER);
  assign unused_s        = ^{inst_DX[24:12], inst_DX[6:0], rs1_data[0]};

  // Decode the requested redirect and its target; misaligned targets are dropped when checking is on
  always_comb begin
    redirect_valid_s  = 1'b0;
    redirect_target_s = {XLEN{1'b0}};
    case (PC_src_sel)
      SEL_BRANCH: begin
        redirect_valid_s  = 1'b1;
        redirect_target_s = branch_target_s;
      end
      SEL_REG: begin
        redirect_valid_s  = 1'b1;
        redirect_target_s = reg_target_s;
      end
      SEL_JAL: begin
        redirect_valid_s  = 1'b1;
        redirect_target_s = alu_out;
      end
      SEL_HANDLER: begin
        redirect_valid_s  = 1'b1;
        redirect_target_s = handler_PC;
      end
      default: begin
        redirect_valid_s  = 1'b0;
        redirect_target_s = {XLEN{1'b0}};
      end
    endcase
`ifdef VSCALE_PC_MISALIGN_EN
    misaligned_s = 1'b0;
    if (redirect_valid_s && !is_handler_s && redirect_target_s[1]) begin
      misaligned_s     = 1'b1;
      redirect_valid_s = 1'b0;
    end else begin
      misaligned_s = 1'b0;
    end
`endif
  end

  // Next fetch address; a handler wins even over a latched redirect
  always_comb begin
    PC_PIF = plus4_s;
    if (reset) begin
      PC_PIF = RESET_VECTOR;
    end else if (is_handler_s) begin
      PC_PIF = handler_PC;
    end else if (pending_valid_r) begin
      PC_PIF = pending_target_r;
    end else if (redirect_valid_s) begin
      PC_PIF = redirect_target_s;
    end else if ((PC_src_sel == SEL_REPLAY) || stall_IF) begin
      PC_PIF = PC_IF;
    end else begin
      PC_PIF = plus4_s;
    end
  end

  // PC pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_IF <= RESET_VECTOR - FOUR;
      PC_DX <= {XLEN{1'b0}};
    end else begin
      if (!stall_IF) begin
        PC_IF <= PC_PIF;
      end
      if (!stall_DX) begin
        PC_DX <= PC_IF;
      end
    end
  end

  // Redirects seen while fetch is stalled are held until fetch can take them
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid_r  <= 1'b0;
      pending_target_r <= {XLEN{1'b0}};
    end else if (!stall_IF) begin
      pending_valid_r <= 1'b0;
    end else if (redirect_valid_s) begin
      pending_valid_r  <= 1'b1;
      pending_target_r <= redirect_target_s;
    end
  end

  assign redirect_pending = pending_valid_r;

`ifdef VSCALE_PC_MISALIGN_EN
  // One-cycle flag for a suppressed misaligned redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      target_misaligned_r <= 1'b0;
    end else begin
      target_misaligned_r <= misaligned_s;
    end
  end

  assign target_misaligned = target_misaligned_r;
`endif

endmodule

// File: tb/tb_vscale_pc_gen.sv
// Directed self-checking bench for vscale_pc_gen (default parameters).
module tb_vscale_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PC_src_sel;
  logic [31:0] inst_DX;
  logic [31:0] alu_out;
  logic [31:0] rs1_data;
  logic [31:0] handler_PC;
  logic        stall_IF;
  logic        stall_DX;
  logic [31:0] PC_PIF;
  logic [31:0] PC_IF;
  logic [31:0] PC_DX;
  logic        redirect_pending;
`ifdef VSCALE_PC_MISALIGN_EN
  logic        target_misaligned;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  vscale_pc_gen dut (
    .clk(clk), .reset(reset), .PC_src_sel(PC_src_sel), .inst_DX(inst_DX),
    .alu_out(alu_out), .rs1_data(rs1_data), .handler_PC(handler_PC),
    .stall_IF(stall_IF), .stall_DX(stall_DX), .PC_PIF(PC_PIF), .PC_IF(PC_IF),
    .PC_DX(PC_DX), .redirect_pending(redirect_pending)
`ifdef VSCALE_PC_MISALIGN_EN
    , .target_misaligned(target_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; PC_src_sel = 3'd0; inst_DX = 32'h0; alu_out = 32'h0;
    rs1_data = 32'h0; handler_PC = 32'h0; stall_IF = 1'b0; stall_DX = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pif", PC_PIF, 32'h200);
    chk("rst_if", PC_IF, 32'h1FC);
    chk("rst_dx", PC_DX, 32'h0);
    chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
    reset = 1'b0; #1;
    chk("rel_pif", PC_PIF, 32'h200);
    tick(); chk("seq_if0", PC_IF, 32'h200); chk("seq_dx0", PC_DX, 32'h1FC); chk("seq_pif", PC_PIF, 32'h204);
    tick(); chk("seq_if1", PC_IF, 32'h204); chk("seq_dx1", PC_DX, 32'h200);
    tick(); chk("seq_if2", PC_IF, 32'h208); chk("seq_dx2", PC_DX, 32'h204);

    // JAL to 0x300, then let it reach DX
    PC_src_sel = 3'd3; alu_out = 32'h300; #1;
    chk("jal_pif", PC_PIF, 32'h300);
    tick(); chk("jal_if", PC_IF, 32'h300);
    PC_src_sel = 3'd0;
    tick(); chk("jal_dx", PC_DX, 32'h300); chk("jal_if4", PC_IF, 32'h304);

    // Backward branch, imm_b = -4
    PC_src_sel = 3'd1; inst_DX = 32'hFE000EE3; #1;
    chk("br_pif", PC_PIF, 32'h2FC);
    tick(); chk("br_if", PC_IF, 32'h2FC);

    // Redirect during a 3-cycle stall
    PC_src_sel = 3'd3; alu_out = 32'h1000; stall_IF = 1'b1; #1;
    chk("stl_pend0", {31'd0, redirect_pending}, 32'd0);
    tick(); chk("stl_pend1", {31'd0, redirect_pending}, 32'd1); chk("stl_if1", PC_IF, 32'h2FC);
    PC_src_sel = 3'd0; #1;
    chk("stl_pif", PC_PIF, 32'h1000);
    tick(); chk("stl_pend2", {31'd0, redirect_pending}, 32'd1); chk("stl_if2", PC_IF, 32'h2FC);
    tick(); chk("stl_if3", PC_IF, 32'h2FC);
    stall_IF = 1'b0; #1;
    chk("rel_pif2", PC_PIF, 32'h1000);
    tick(); chk("rel_if", PC_IF, 32'h1000); chk("rel_pend", {31'd0, redirect_pending}, 32'd0);
    chk("rel_pif3", PC_PIF, 32'h1004);

    // Handler overrides a pending redirect when unstalled
    PC_src_sel = 3'd3; alu_out = 32'h1000; stall_IF = 1'b1;
    tick(); chk("hp_pend", {31'd0, redirect_pending}, 32'd1);
    PC_src_sel = 3'd5; handler_PC = 32'h100; stall_IF = 1'b0; #1;
    chk("hp_pif", PC_PIF, 32'h100);
    tick(); chk("hp_if", PC_IF, 32'h100); chk("hp_pend0", {31'd0, redirect_pending}, 32'd0);

    // Handler during a stall overwrites the latched target
    PC_src_sel = 3'd3; alu_out = 32'h2000; stall_IF = 1'b1;
    tick();
    PC_src_sel = 3'd5; handler_PC = 32'h180; #1;
    chk("ho_pif", PC_PIF, 32'h180);
    tick(); PC_src_sel = 3'd0; #1;
    chk("ho_pend_tgt", PC_PIF, 32'h180);
    stall_IF = 1'b0;
    tick(); chk("ho_if", PC_IF, 32'h180);

    // JALR clears bit 0; then wrap past the top of the address space
    PC_src_sel = 3'd2; rs1_data = 32'h401; #1;
    chk("jalr_pif", PC_PIF, 32'h400);
    tick(); chk("jalr_if", PC_IF, 32'h400);
    rs1_data = 32'hFFFFFFFC;
    tick(); chk("wr_if", PC_IF, 32'hFFFFFFFC);
    PC_src_sel = 3'd0; #1;
    chk("wr_pif", PC_PIF, 32'h0);
    tick(); chk("wr_if0", PC_IF, 32'h0); chk("wr_dx", PC_DX, 32'hFFFFFFFC);

    // REPLAY holds fetch; select 6 behaves as PLUS_FOUR; stall_DX holds PC_DX
    PC_src_sel = 3'd4; #1;
    chk("rp_pif", PC_PIF, 32'h0);
    tick(); chk("rp_if", PC_IF, 32'h0);
    PC_src_sel = 3'd6; stall_DX = 1'b1; #1;
    chk("s6_pif", PC_PIF, 32'h4);
    tick(); chk("s6_if", PC_IF, 32'h4);
    PC_src_sel = 3'd7;
    tick(); chk("sdx_if", PC_IF, 32'h8); chk("sdx_dx", PC_DX, 32'h0);
    stall_DX = 1'b0;

    // JAL to an address with bit 1 set
    PC_src_sel = 3'd3; alu_out = 32'h402; #1;
`ifdef VSCALE_PC_MISALIGN_EN
    chk("mis_pif", PC_PIF, 32'hC);
    tick(); chk("mis_flag1", {31'd0, target_misaligned}, 32'd1); chk("mis_if", PC_IF, 32'hC);
    PC_src_sel = 3'd0;
    tick(); chk("mis_flag0", {31'd0, target_misaligned}, 32'd0);
`else
    chk("mis_pif", PC_PIF, 32'h402);
    tick(); chk("mis_if", PC_IF, 32'h402);
`endif

    // Reset mid-run
    reset = 1'b1; #1;
    chk("rr_pif", PC_PIF, 32'h200);
    tick(); chk("rr_if", PC_IF, 32'h1FC); chk("rr_dx", PC_DX, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_pc_gen.md
Name: vscale_pc_gen

Overview:
- Parametrised next-PC generation unit for the vscale fetch stage.
- Selects the next fetch address (PC_PIF) and owns the PC_IF and PC_DX registers.
- Latches redirects that arrive while fetch is stalled and replays them when the stall clears, so no control-flow change is lost.
- Sits between the control unit (PC_src_sel, stalls) and the instruction-memory request port.

Parameters:
XLEN, 32, datapath/PC width in bits (>=16)
SEL_W, 3, width of PC_src_sel
RESET_VECTOR, 32'h200, first fetch address after reset (XLEN wide)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
PC_src_sel  input  SEL_W  0=PLUS_FOUR 1=BRANCH 2=REG 3=JAL 4=REPLAY 5=HANDLER; 6,7 treated as PLUS_FOUR
inst_DX  input  32  instruction in DX; supplies B-immediate
alu_out  input  XLEN  JAL target
rs1_data  input  XLEN  JALR target (bit0 cleared internally)
handler_PC  input  XLEN  trap/interrupt handler address
stall_IF  input  1  fetch cannot advance (imem not ready or pipeline hold)
stall_DX  input  1  DX stage holds
PC_PIF  output  XLEN  next fetch address (combinational)
PC_IF  output  XLEN  registered address of instruction in IF
PC_DX  output  XLEN  registered address of instruction in DX
redirect_pending  output  1  registered; a latched redirect awaits release

Behaviour:
- One clock domain; all state updates on posedge clk; reset is synchronous and active-high.
- Reset:
  - PC_IF <= RESET_VECTOR-4; PC_DX <= 0.
  - pending_valid <= 0 and pending_target <= 0, so redirect_pending = 0.
  - While reset is high, PC_PIF = RESET_VECTOR.
- Target computation, all modulo 2^XLEN:
  - imm_b = sign-extend({inst_DX[31], inst_DX[7], inst_DX[30:25], inst_DX[11:8], 1'b0}) to XLEN.
  - branch = PC_DX + imm_b.
  - reg = rs1_data & ~1.
  - jal = alu_out.
  - plus4 = PC_IF + 4; wraps silently at 2^XLEN.
- "Redirect" means sel in {BRANCH, REG, JAL, HANDLER}.
- PC_PIF priority, highest first:
  1. reset -> RESET_VECTOR.
  2. sel==HANDLER -> handler_PC, also when stalled or pending.
  3. pending_valid -> pending_target.
  4. other redirect -> its target.
  5. REPLAY or stall_IF -> PC_IF.
  6. otherwise plus4.
- PC_IF update: PC_IF <= PC_PIF when !stall_IF; hold otherwise.
- PC_DX update: PC_DX <= PC_IF when !stall_DX; hold otherwise.
- Pending latch:
  - If stall_IF and a redirect is present: pending_valid <= 1, pending_target <= that target. Latest redirect overwrites; HANDLER always overwrites.
  - If !stall_IF: pending_valid <= 0, since the pending target is consumed via PC_PIF that cycle.
  - Stalled and no new redirect: pending state holds.
- Redirect and !stall_IF in the same cycle: applied directly, nothing latched.
- Latency:
  - Redirect to PC_IF is 1 cycle when unstalled.
  - Redirect during a stall reaches PC_IF in the cycle after stall_IF deasserts.

Optional Feature:
VSCALE_PC_MISALIGN_EN
- Defined:
  - Adds output target_misaligned (1 bit, registered, reset 0).
  - A BRANCH/JAL/REG redirect whose target has bit1 set is suppressed: not applied, not latched; PC_PIF follows the remaining priority.
  - target_misaligned pulses high for one cycle on the following edge.
  - HANDLER redirects are never checked.
- Undefined: the port is absent and all targets are accepted unchanged.

Test Plan:
- Reset, RESET_VECTOR=0x200: hold reset 2 cycles, release with sel=PLUS_FOUR -> PC_PIF=0x200 during reset; PC_IF 0x200, 0x204, 0x208 on successive cycles; PC_DX lags PC_IF by one cycle.
- Branch: PC_DX=0x300, inst_DX=0xFE000EE3 (imm_b=-4), sel=BRANCH -> PC_PIF=0x2FC; next PC_IF=0x2FC.
- Stalled redirect: stall_IF=1 for 3 cycles, JAL with alu_out=0x1000 in cycle 1 -> redirect_pending=1 from cycle 2; PC_IF held; first unstalled cycle PC_PIF=0x1000; redirect_pending=0 next cycle.
- Handler priority: pending_target=0x1000 with sel=HANDLER, handler_PC=0x100, stall_IF=0 -> PC_PIF=0x100; pending cleared.
- JALR/wrap: sel=REG, rs1_data=0x401 -> PC_PIF=0x400. Then PC_IF=0xFFFFFFFC with PLUS_FOUR -> PC_PIF=0x0.
- Misalign (macro defined): sel=JAL, alu_out=0x402 -> PC_PIF=PC_IF+4; target_misaligned=1 for exactly one cycle. Same stimulus without the macro -> PC_PIF=0x402.
